// File: rtl/tick_pkg.sv
// Shared definitions for the tick scheduler: FSM encoding and board defaults.
package tick_pkg;

  localparam int TICK_CNT_W = 32;
  // 5000-cycle tick period on the 50 MHz board clock
  localparam int BOARD_DEFAULT_DIV = 4999;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    PEND = ST_PEND
  } state_t;

endpackage

// File: rtl/tick_scheduler_terminal_counter.sv
// Free-running up-counter that clears when not running and wraps after
// reaching its limit; tc flags the cycle in which the limit is reached.
module terminal_counter
  import tick_pkg::*;
#(
  parameter int CNT_W = TICK_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] r_count;

  assign tc    = run && (r_count == limit);
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      r_count <= '0;
    end else if (tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Programmable clock-enable divider: one-cycle tick plus toggling divided_clk,
// with new divide values applied only at period boundaries.
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int               CNT_W       = TICK_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(BOARD_DEFAULT_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             divided_clk,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_div_active;
  logic [CNT_W-1:0] w_div_active_next;
  logic [CNT_W-1:0] r_div_pend;
  logic [CNT_W-1:0] w_div_pend_next;
  logic             r_tick;
  logic             r_div_clk;
  logic             r_cfg_ready;
  logic             r_busy;
  logic             w_run;
  logic             w_tc;
  logic             w_accept;
  logic [CNT_W-1:0] w_count;
  logic             w_unused_count;

  // Dropping enable stops the counter on the same edge, so no tick can escape.
  assign w_run          = (r_state != IDLE) && enable;
  assign w_accept       = cfg_valid && r_cfg_ready;
  assign w_unused_count = ^w_count;

  terminal_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .run   (w_run),
    .limit (r_div_active),
    .count (w_count),
    .tc    (w_tc)
  );

  always_comb begin
    w_state_next      = r_state;
    w_div_active_next = r_div_active;
    w_div_pend_next   = r_div_pend;
    case (r_state)
      IDLE: begin
        if (w_accept) w_div_active_next = cfg_div;
        if (enable) w_state_next = RUN;
      end
      RUN: begin
        if (!enable) begin
          w_state_next = IDLE;
          if (w_accept) w_div_active_next = cfg_div;
        end else if (w_accept) begin
          // An accept on the terminal edge lands exactly on a boundary.
          if (w_tc) begin
            w_div_active_next = cfg_div;
          end else begin
            w_div_pend_next = cfg_div;
            w_state_next    = PEND;
          end
        end
      end
      PEND: begin
        if (!enable || w_tc) begin
          w_div_active_next = r_div_pend;
          w_state_next      = enable ? RUN : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_div_active <= DEFAULT_DIV;
      r_div_pend   <= '0;
      r_tick       <= 1'b0;
      r_div_clk    <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_div_active <= w_div_active_next;
      r_div_pend   <= w_div_pend_next;
      r_tick       <= w_tc;
      r_div_clk    <= r_div_clk ^ w_tc;
      r_cfg_ready  <= (w_state_next != PEND);
      r_busy       <= (w_state_next != IDLE);
    end
  end

  assign tick        = r_tick;
  assign divided_clk = r_div_clk;
  assign cfg_ready   = r_cfg_ready;
  assign busy        = r_busy;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: expected tick cycles and divided_clk
// levels are queued as stimulus is applied and matched against observed ticks.
module tb_tick_scheduler;
  import tick_pkg::*;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             tick;
  logic             divided_clk;
  logic             busy;

  typedef struct {
    int t;
    bit dclk;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  total;
  int  bad;
  int  cyc;
  int  t_ref;
  bit  m_dclk;

  tick_scheduler #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (32'd4999)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .tick        (tick),
    .divided_clk (divided_clk),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every tick with the edge number that produced it.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      ev_t o;
      o.t    = cyc;
      o.dclk = divided_clk;
      obs_q.push_back(o);
    end
  end

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_obs(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (obs_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_tick(input int t);
    ev_t e;
    m_dclk = ~m_dclk;
    e.t    = t;
    e.dclk = m_dclk;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    m_dclk = 1'b0;
    goto(3);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0b required 0", tick); end
    total++; if (divided_clk !== 1'b0) begin bad++; $display("FAIL reset_dclk: got %0b required 0", divided_clk); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b required 1", cfg_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
    total++; if (dut.r_div_active !== 32'd4999) begin bad++; $display("FAIL reset_div: got %0d required 4999", dut.r_div_active); end
    rst = 1'b0;
  endtask

  task automatic test_default_div;
    int e_edge;
    ev_t e, o;
    bit ok;
    goto(cyc + 2);
    e_edge = cyc + 1;
    enable = 1'b1;
    expect_tick(e_edge + 5000);
    expect_tick(e_edge + 10000);
    goto(e_edge);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_busy: got %0b required 1", busy); end
    goto(e_edge + 10000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_obs(12000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL default_tick: no tick, required cycle=%0d", e.t); exp_q.delete(); end
      else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.dclk !== e.dclk) begin bad++; $display("FAIL default_tick: got cycle=%0d dclk=%0b required cycle=%0d dclk=%0b", o.t, o.dclk, e.t, e.dclk); end
      end
    end
    t_ref = e_edge + 10000;
  endtask

  task automatic test_pend;
    int x, t3;
    ev_t e, o;
    bit ok;
    x = t_ref;
    t3 = x + 5000;
    goto(x + 100);
    cfg_valid = 1'b1; cfg_div = 32'd9;
    goto(x + 101);
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL pend_ready: got %0b required 0", cfg_ready); end
    expect_tick(t3);
    expect_tick(t3 + 10);
    expect_tick(t3 + 20);
    goto(t3 - 1);
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL pend_hold_ready: got %0b required 0", cfg_ready); end
    goto(t3);
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL pend_release_ready: got %0b required 1", cfg_ready); end
    goto(t3 + 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_obs(12000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL pend_tick: no tick, required cycle=%0d", e.t); exp_q.delete(); end
      else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.dclk !== e.dclk) begin bad++; $display("FAIL pend_tick: got cycle=%0d dclk=%0b required cycle=%0d dclk=%0b", o.t, o.dclk, e.t, e.dclk); end
      end
    end
    t_ref = t3 + 20;
  endtask

  task automatic test_cfg_at_tc;
    int y;
    ev_t e, o;
    bit ok;
    y = t_ref;
    goto(y + 9);
    cfg_valid = 1'b1; cfg_div = 32'd3;
    goto(y + 10);
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL tc_cfg_ready: got %0b required 1", cfg_ready); end
    expect_tick(y + 10);
    expect_tick(y + 14);
    expect_tick(y + 18);
    goto(y + 19);
    enable = 1'b0;
    goto(y + 24);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_obs(200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL tc_tick: no tick, required cycle=%0d", e.t); exp_q.delete(); end
      else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.dclk !== e.dclk) begin bad++; $display("FAIL tc_tick: got cycle=%0d dclk=%0b required cycle=%0d dclk=%0b", o.t, o.dclk, e.t, e.dclk); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL tc_extra_tick: got %0d extra ticks required 0", obs_q.size()); obs_q.delete(); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tc_stop_busy: got %0b required 0", busy); end
  endtask

  task automatic test_div0;
    int e_edge;
    ev_t e, o;
    bit ok;
    goto(cyc + 1);
    cfg_valid = 1'b1; cfg_div = 32'd0;
    goto(cyc + 1);
    cfg_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL div0_idle_busy: got %0b required 0", busy); end
    goto(cyc + 2);
    e_edge = cyc + 1;
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) expect_tick(e_edge + k);
    goto(e_edge + 8);
    enable = 1'b0;
    goto(e_edge + 12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_obs(200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL div0_tick: no tick, required cycle=%0d", e.t); exp_q.delete(); end
      else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.dclk !== e.dclk) begin bad++; $display("FAIL div0_tick: got cycle=%0d dclk=%0b required cycle=%0d dclk=%0b", o.t, o.dclk, e.t, e.dclk); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL div0_extra_tick: got %0d extra ticks required 0", obs_q.size()); obs_q.delete(); end
    total++; if (divided_clk !== m_dclk) begin bad++; $display("FAIL div0_dclk_hold: got %0b required %0b", divided_clk, m_dclk); end
  endtask

  task automatic test_disable_pend;
    int e_edge, r_edge;
    ev_t e, o;
    bit ok;
    goto(cyc + 1);
    cfg_valid = 1'b1; cfg_div = 32'd4999;
    goto(cyc + 1);
    cfg_valid = 1'b0;
    goto(cyc + 1);
    e_edge = cyc + 1;
    enable = 1'b1;
    goto(e_edge + 1000);
    cfg_valid = 1'b1; cfg_div = 32'd19;
    goto(e_edge + 1001);
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL dis_pend_ready: got %0b required 0", cfg_ready); end
    goto(e_edge + 2000);
    enable = 1'b0;
    goto(e_edge + 2001);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dis_busy: got %0b required 0", busy); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL dis_ready: got %0b required 1", cfg_ready); end
    total++; if (dut.w_count !== 32'd0) begin bad++; $display("FAIL dis_count: got %0d required 0", dut.w_count); end
    total++; if (divided_clk !== m_dclk) begin bad++; $display("FAIL dis_dclk_hold: got %0b required %0b", divided_clk, m_dclk); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL dis_tick: got %0d ticks required 0", obs_q.size()); obs_q.delete(); end
    goto(e_edge + 2005);
    r_edge = cyc + 1;
    enable = 1'b1;
    expect_tick(r_edge + 20);
    expect_tick(r_edge + 40);
    goto(r_edge + 40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_obs(12000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL dis_reenable_tick: no tick, required cycle=%0d", e.t); exp_q.delete(); end
      else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.dclk !== e.dclk) begin bad++; $display("FAIL dis_reenable_tick: got cycle=%0d dclk=%0b required cycle=%0d dclk=%0b", o.t, o.dclk, e.t, e.dclk); end
      end
    end
    t_ref = r_edge + 40;
  endtask

  task automatic test_reset_in_pend;
    int z, e2;
    ev_t e, o;
    bit ok;
    z = t_ref;
    goto(z + 4);
    cfg_valid = 1'b1; cfg_div = 32'd4999;
    goto(z + 5);
    cfg_valid = 1'b0;
    expect_tick(z + 20);
    goto(z + 21);
    cfg_valid = 1'b1; cfg_div = 32'd7;
    goto(z + 22);
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_pend_ready: got %0b required 0", cfg_ready); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_obs(200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rst_pre_tick: no tick, required cycle=%0d", e.t); exp_q.delete(); end
      else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.dclk !== e.dclk) begin bad++; $display("FAIL rst_pre_tick: got cycle=%0d dclk=%0b required cycle=%0d dclk=%0b", o.t, o.dclk, e.t, e.dclk); end
      end
    end
    goto(z + 2520);
    rst = 1'b1; enable = 1'b0;
    goto(z + 2521);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_tick: got %0b required 0", tick); end
    total++; if (divided_clk !== 1'b0) begin bad++; $display("FAIL rst_dclk: got %0b required 0", divided_clk); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b required 1", cfg_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b required 0", busy); end
    total++; if (dut.r_div_active !== 32'd4999) begin bad++; $display("FAIL rst_div: got %0d required 4999", dut.r_div_active); end
    rst = 1'b0;
    m_dclk = 1'b0;
    obs_q.delete();
    goto(cyc + 2);
    e2 = cyc + 1;
    enable = 1'b1;
    expect_tick(e2 + 5000);
    goto(e2 + 5000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_obs(12000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rst_post_tick: no tick, required cycle=%0d", e.t); exp_q.delete(); end
      else begin
        o = obs_q.pop_front();
        if (o.t !== e.t || o.dclk !== e.dclk) begin bad++; $display("FAIL rst_post_tick: got cycle=%0d dclk=%0b required cycle=%0d dclk=%0b", o.t, o.dclk, e.t, e.dclk); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    t_ref = 0;
    test_reset();
    test_default_div();
    test_pend();
    test_cfg_at_tc();
    test_div0();
    test_disable_pend();
    test_reset_in_pend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Run-time controller for the board's clock-enable divider. It counts `clk` cycles against a programmable terminal value and emits a one-cycle `tick` plus a square-wave `divided_clk` that toggles on every tick. New divide values arrive over a valid/ready handshake and take effect only at a period boundary, so the output has no glitches or truncated half-periods. It sits between the 50 MHz board clock and the LED/display logic, which consume `tick` as a clock enable.

## Interface
Parameters:
- `CNT_W`, 32: counter and divide-value width.
- `DEFAULT_DIV`, 4999: terminal value loaded at reset (5000-cycle tick period, 5 kHz `divided_clk` at 50 MHz).

Ports:
- `clk`  in  1  system clock, 50 MHz; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; 1 = run, 0 = stop and hold.
- `cfg_valid`  in  1  new divide value offered.
- `cfg_div`  in  CNT_W  terminal value; tick period = `cfg_div`+1 cycles.
- `cfg_ready`  out  1  block can accept a value this cycle.
- `tick`  out  1  registered one-cycle pulse at each terminal count.
- `divided_clk`  out  1  toggles on every tick; period 2·(div+1) cycles.
- `busy`  out  1  high in RUN and PEND.

## Operation
- Registers: `count`, `div_active`, `div_pend`, state.
- Reset values: `count`=0, `div_active`=DEFAULT_DIV, state IDLE, `divided_clk`=0, `tick`=0, `cfg_ready`=1, `busy`=0.
- A handshake completes on any edge where `cfg_valid && cfg_ready`.
- IDLE
  - `count` is held at 0 and `divided_clk` holds its value.
  - `cfg_ready`=1. An accepted value is written directly to `div_active`.
  - `enable`=1 moves the block to RUN.
- RUN
  - `count` increments each cycle.
  - When `count==div_active`: `count`→0, `divided_clk` toggles, `tick`=1.
  - `cfg_ready`=1. An accepted value goes to `div_pend` and the state moves to PEND.
  - If the accept coincides with the terminal count, the value goes straight to `div_active` and the state stays RUN.
- PEND
  - Counts exactly as RUN, with `cfg_ready`=0.
  - At terminal count: `div_active`←`div_pend`, `count`→0, toggle, tick, then back to RUN.
- `enable`=0 in RUN or PEND
  - Next state is IDLE and `count`→0.
  - A pending value is copied into `div_active`.
  - No tick is produced and `divided_clk` holds.
- `div`=0 is legal: a tick every cycle, and `divided_clk` toggles every cycle.
- Widths and arithmetic:
  - The compare is an unsigned equality.
  - `count` never exceeds `div_active`, so no wrap occurs.
  - `div_active` = 2^CNT_W−1 is legal.
- `rst` has priority over all other inputs in every state. Mid-period reset restores the reset values; the pending value is discarded.

## Timing
- `enable` sampled high at edge E (state IDLE) gives RUN from E, and the first `tick` is high in the cycle after edge E+div_active+1.
- With DEFAULT_DIV: the first tick follows edge E+5000, then one every 5000 cycles.
- `tick` and the `divided_clk` toggle appear in the same cycle.
- Config latency:
  - IDLE: the new value is used from the next RUN entry.
  - RUN/PEND: the new value is used from the period that starts after the current terminal count.
- `cfg_ready` is a registered function of state only; it never depends combinationally on `cfg_valid`.
- Stop latency: `busy` falls the cycle after `enable` is sampled low.

## Structure
- Shared package `tick_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, PEND=2'd2);
  - the `DEFAULT_DIV` constant for the 50 MHz board.
- One natural sub-module, `terminal_counter`:
  - inputs: `clk`, `rst`, `run`, `limit`;
  - outputs: `count`, `tc`;
  - clears on `!run` and wraps at `limit`.
- `tick_scheduler` owns the FSM, the config registers and the output flops.

## Test plan
- Reset then `enable`=1 at edge E, default div: first `tick` after E+5000, second after E+10000, `divided_clk` 0→1→0.
- In RUN, count=100, write `cfg_div`=9: PEND, `cfg_ready`=0, the current 5000-cycle period completes, then ticks every 10 cycles and `cfg_ready` returns to 1.
- Handshake in the same cycle as the terminal count with `cfg_div`=3: the next period is 4 cycles and the state stays RUN.
- `cfg_div`=0 from IDLE, then enable: `tick` is constant 1 and `divided_clk` toggles every cycle.
- Drop `enable` mid-period with a value pending (div 4999→19):
  - expect IDLE, `count`=0, `divided_clk` held, no tick;
  - after re-enable, the first tick comes 20 cycles later.
- Assert `rst` in PEND at count=2500: all reset values next cycle, `div_active`=4999, and the pending value is lost.
